// File: rtl/rfphoenix_dcache_fill_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rfphoenix_dcache_fill_ctrl_if                                            |
// | Miss request, bus read burst and cache array write signals of the filler |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rfphoenix_dcache_fill_ctrl_if #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int BEATS = 8
) ();
    logic                  req_i;
    logic [AW-1:0]         adr_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    logic                  cyc_o;
    logic                  stb_o;
    logic [AW-1:0]         adr_o;
    logic                  ack_i;
    logic                  err_i;
    logic [DW-1:0]         dat_i;

    logic                  wr_o;
    logic [1:0]            wway_o;
    logic [AW-1:0]         wadr_o;
    logic [BEATS*DW-1:0]   line_o;

    // Fill controller side
    modport master (
        input  req_i, adr_i, ack_i, err_i, dat_i,
        output busy_o, done_o, err_o, cyc_o, stb_o, adr_o,
               wr_o, wway_o, wadr_o, line_o
    );

    // Requester / bus / cache array side
    modport slave (
        output req_i, adr_i, ack_i, err_i, dat_i,
        input  busy_o, done_o, err_o, cyc_o, stb_o, adr_o,
               wr_o, wway_o, wadr_o, line_o
    );
endinterface
`default_nettype wire

// File: rtl/rfphoenix_dcache_fill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rfphoenix_dcache_fill_ctrl                                               |
// | Data-cache line fill sequencer: LFSR victim pick, burst read, array write|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rfphoenix_dcache_fill_ctrl #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int BEATS = 8,
    parameter int TMO   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    rfphoenix_dcache_fill_ctrl_if.master bus
);
    localparam int              LINE_BYTES = BEATS * DW / 8;
    localparam int              BEAT_BYTES = DW / 8;
    localparam int              BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int              TW         = $clog2(TMO + 1);
    localparam logic [AW-1:0]   LINE_MASK  = ~AW'(LINE_BYTES - 1);
    localparam logic [AW-1:0]   BEAT_STEP  = AW'(BEAT_BYTES);
    localparam logic [BW-1:0]   LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [TW-1:0]   TMO_LAST   = TW'(TMO - 1);
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_WRITE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                 state;
    logic [15:0]            lfsr;
    logic                   lfsr_fb;
    logic [BW-1:0]          beat;
    logic [TW-1:0]          tmo_cnt;

    logic                   busy;
    logic                   done;
    logic                   fail;
    logic                   cyc;
    logic                   stb;
    logic [AW-1:0]          adr;
    logic                   wr;
    logic [1:0]             wway;
    logic [AW-1:0]          wadr;
    logic [BEATS*DW-1:0]    line;
    logic [AW-1:0]          line_base;

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign line_base = bus.adr_i & LINE_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            lfsr    <= LFSR_SEED;
            beat    <= '0;
            tmo_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            adr     <= '0;
            wr      <= 1'b0;
            wway    <= 2'd0;
            wadr    <= '0;
            line    <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            done <= 1'b0;
            fail <= 1'b0;
            wr   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_i) begin
                        // Victim way comes from the pre-shift LFSR value of this edge
                        wway    <= lfsr[1:0];
                        wadr    <= line_base;
                        adr     <= line_base;
                        beat    <= '0;
                        tmo_cnt <= '0;
                        cyc     <= 1'b1;
                        stb     <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_BURST;
                    end
                end

                S_BURST: begin
                    if (bus.err_i) begin
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                        state <= S_ERR;
                    end else if (bus.ack_i) begin
                        line[32'(beat) * DW +: DW] <= bus.dat_i;
                        tmo_cnt <= '0;
                        if (beat == LAST_BEAT) begin
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            wr    <= 1'b1;
                            done  <= 1'b1;
                            state <= S_WRITE;
                        end else begin
                            beat <= beat + 1'b1;
                            adr  <= adr + BEAT_STEP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_WRITE, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    cyc   <= 1'b0;
                    stb   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o = busy;
    assign bus.done_o = done;
    assign bus.err_o  = fail;
    assign bus.cyc_o  = cyc;
    assign bus.stb_o  = stb;
    assign bus.adr_o  = adr;
    assign bus.wr_o   = wr;
    assign bus.wway_o = wway;
    assign bus.wadr_o = wadr;
    assign bus.line_o = line;

endmodule
`default_nettype wire
